// File: rtl/im_fetch_port.sv
// Instruction-memory fetch port with one-entry tagged word buffer.
// IM_ALIGN_CHECK_EN enables misaligned-PC detection on AddrError_OUT.
module im_fetch_port #(
    parameter logic [31:0] NOP_WORD = 32'h00000000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] Address_IN,
    input  logic        Flush_IN,
    input  logic        MemGnt_IN,
    input  logic [31:0] MemRdata_IN,
    input  logic        MemRvalid_IN,
    output logic        MemReq_OUT,
    output logic [31:0] MemAddr_OUT,
    output logic [31:0] Instruction_OUT,
    output logic        InstructionValid_OUT,
    output logic        Stall_OUT,
    output logic        BusError_OUT,
    output logic        AddrError_OUT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ERR
    } state_t;

    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    state_t      state_q, state_d;
    logic        tag_valid_q, tag_valid_d;
    logic [31:0] tag_q, tag_d;
    logic [31:0] data_q, data_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        discard_q, discard_d;
    logic        berr_q, berr_d;

    logic        hit;
    logic        misaligned;
    logic        idle;
    logic        addr_err;
    logic        ivalid;

    assign hit  = tag_valid_q && (tag_q == Address_IN) && !Flush_IN;
    assign idle = (state_q == S_IDLE);

`ifdef IM_ALIGN_CHECK_EN
    assign misaligned = (Address_IN[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign addr_err = idle && misaligned;
    assign ivalid   = idle && hit && !misaligned;

    assign MemReq_OUT           = (state_q == S_REQ);
    assign MemAddr_OUT          = addr_q;
    assign InstructionValid_OUT = ivalid;
    assign Stall_OUT            = !ivalid && !addr_err;
    assign BusError_OUT         = berr_q;
    assign AddrError_OUT        = addr_err;
    assign Instruction_OUT      =
        (hit && (state_q != S_ERR) && !addr_err) ? data_q : NOP_WORD;

    // Next-state: request issue, grant wait, data fill, timeout lockup.
    always_comb begin
        state_d     = state_q;
        tag_valid_d = tag_valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        discard_d   = discard_q;
        berr_d      = berr_q;
        unique case (state_q)
            S_IDLE: begin
                if (!hit && !misaligned) begin
                    addr_d  = Address_IN;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (Flush_IN) discard_d = 1'b1;
                if (MemGnt_IN) begin
                    cnt_d   = 8'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (MemRvalid_IN) begin
                    if (!discard_q && !Flush_IN) begin
                        tag_d       = addr_q;
                        data_d      = MemRdata_IN;
                        tag_valid_d = 1'b1;
                    end
                    discard_d = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (Flush_IN) discard_d = 1'b1;
                    if (cnt_q + 8'd1 == MaxWait) begin
                        berr_d  = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_ERR: begin
                berr_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (Flush_IN) tag_valid_d = 1'b0;
    end

    // State and buffer registers.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            tag_valid_q <= 1'b0;
            tag_q       <= 32'd0;
            data_q      <= 32'd0;
            addr_q      <= 32'd0;
            cnt_q       <= 8'd0;
            discard_q   <= 1'b0;
            berr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_valid_q <= tag_valid_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            discard_q   <= discard_d;
            berr_q      <= berr_d;
        end
    end

endmodule

// File: tb/tb_im_fetch_port.sv
// Bench for im_fetch_port: directed scenarios plus randomized bus traffic
// checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_im_fetch_port;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam int MAXW = 16;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [31:0] Address_IN;
    logic        Flush_IN;
    logic        MemGnt_IN;
    logic [31:0] MemRdata_IN;
    logic        MemRvalid_IN;
    logic        MemReq_OUT;
    logic [31:0] MemAddr_OUT;
    logic [31:0] Instruction_OUT;
    logic        InstructionValid_OUT;
    logic        Stall_OUT;
    logic        BusError_OUT;
    logic        AddrError_OUT;

    im_fetch_port #(.NOP_WORD(NOP), .MAX_WAIT(MAXW)) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .Address_IN(Address_IN),
        .Flush_IN(Flush_IN),
        .MemGnt_IN(MemGnt_IN),
        .MemRdata_IN(MemRdata_IN),
        .MemRvalid_IN(MemRvalid_IN),
        .MemReq_OUT(MemReq_OUT),
        .MemAddr_OUT(MemAddr_OUT),
        .Instruction_OUT(Instruction_OUT),
        .InstructionValid_OUT(InstructionValid_OUT),
        .Stall_OUT(Stall_OUT),
        .BusError_OUT(BusError_OUT),
        .AddrError_OUT(AddrError_OUT)
    );

    always #5 CLOCK = ~CLOCK;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding fetch, a buffered word, a dead flag.
    bit          m_busy = 0;
    bit          m_granted = 0;
    int          m_elapsed = 0;
    bit          m_drop = 0;
    logic [31:0] m_req_addr = 32'd0;
    bit          m_buf_ok = 0;
    logic [31:0] m_buf_tag = 32'd0;
    logic [31:0] m_buf_data = 32'd0;
    bit          m_dead = 0;

    function automatic bit m_hit();
        return m_buf_ok && (m_buf_tag == Address_IN) && !Flush_IN;
    endfunction

    function automatic bit m_mis();
`ifdef IM_ALIGN_CHECK_EN
        return Address_IN[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            m_busy <= 0; m_granted <= 0; m_elapsed <= 0; m_drop <= 0;
            m_req_addr <= 32'd0; m_buf_ok <= 0; m_buf_tag <= 32'd0;
            m_buf_data <= 32'd0; m_dead <= 0;
        end else if (m_dead) begin
            if (Flush_IN) m_buf_ok <= 0;
        end else if (!m_busy) begin
            if (!m_mis() && !m_hit()) begin
                m_busy <= 1; m_granted <= 0; m_drop <= 0;
                m_req_addr <= Address_IN;
            end
            if (Flush_IN) m_buf_ok <= 0;
        end else if (!m_granted) begin
            if (MemGnt_IN) begin m_granted <= 1; m_elapsed <= 0; end
            if (Flush_IN) begin m_drop <= 1; m_buf_ok <= 0; end
        end else if (MemRvalid_IN) begin
            m_busy <= 0;
            if (!m_drop && !Flush_IN) begin
                m_buf_ok <= 1; m_buf_tag <= m_req_addr; m_buf_data <= MemRdata_IN;
            end else if (Flush_IN) begin
                m_buf_ok <= 0;
            end
        end else begin
            m_elapsed <= m_elapsed + 1;
            if (Flush_IN) begin m_drop <= 1; m_buf_ok <= 0; end
            if (m_elapsed + 1 == MAXW) begin m_dead <= 1; m_busy <= 0; end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CLOCK) begin
        if (cmp_on) begin
            bit idle, hit, mis, aerr, val;
            idle = !m_busy && !m_dead;
            hit  = m_hit();
            mis  = m_mis();
            aerr = idle && mis;
            val  = idle && hit && !mis;
            chk("req", 32'(MemReq_OUT), 32'(m_busy && !m_granted));
            chk("addr", MemAddr_OUT, m_req_addr);
            chk("valid", 32'(InstructionValid_OUT), 32'(val));
            chk("stall", 32'(Stall_OUT), 32'(!val && !aerr));
            chk("instr", Instruction_OUT,
                (hit && !m_dead && !aerr) ? m_buf_data : NOP);
            chk("berr", 32'(BusError_OUT), 32'(m_dead));
            chk("aerr", 32'(AddrError_OUT), 32'(aerr));
        end
    end

    task automatic nxt();
        @(posedge CLOCK); #1;
    endtask

    task automatic neg();
        @(negedge CLOCK); #1;
    endtask

    logic [31:0] pool [6] = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008,
                              32'hBFC0000C, 32'h00001000, 32'hBFC00006};
    int rv_cnt = -1;
    bit drained;

    initial begin
        RESET = 1'b0; Address_IN = 32'hBFC00000; Flush_IN = 0;
        MemGnt_IN = 0; MemRdata_IN = 0; MemRvalid_IN = 0;
        repeat (2) nxt();
        cmp_on = 1'b1;
        neg();
        chk("rst_stall", 32'(Stall_OUT), 32'd1);
        chk("rst_req", 32'(MemReq_OUT), 32'd0);
        chk("rst_instr", Instruction_OUT, NOP);
        chk("rst_berr", 32'(BusError_OUT), 32'd0);
        nxt();
        RESET = 1'b1;

        // cold miss on the reset vector, zero-wait bus
        neg(); chk("c0_stall", 32'(Stall_OUT), 32'd1);
        chk("c0_req", 32'(MemReq_OUT), 32'd0);
        nxt(); MemGnt_IN = 1;
        neg(); chk("c1_req", 32'(MemReq_OUT), 32'd1);
        chk("c1_addr", MemAddr_OUT, 32'hBFC00000);
        chk("c1_stall", 32'(Stall_OUT), 32'd1);
        nxt(); MemGnt_IN = 0; MemRvalid_IN = 1; MemRdata_IN = 32'h3C1D0001;
        neg(); chk("c2_req", 32'(MemReq_OUT), 32'd0);
        chk("c2_stall", 32'(Stall_OUT), 32'd1);
        nxt(); MemRvalid_IN = 0;
        neg(); chk("c3_instr", Instruction_OUT, 32'h3C1D0001);
        chk("c3_valid", 32'(InstructionValid_OUT), 32'd1);
        for (int i = 0; i < 5; i++) begin
            nxt(); neg();
            chk("hold_req", 32'(MemReq_OUT), 32'd0);
            chk("hold_valid", 32'(InstructionValid_OUT), 32'd1);
        end

        // next PC, grant delayed three cycles while PC moves on
        nxt(); Address_IN = 32'hBFC00004;
        neg(); chk("s4_stall", 32'(Stall_OUT), 32'd1);
        nxt(); Address_IN = 32'hBFC00100;
        for (int i = 0; i < 4; i++) begin
            MemGnt_IN = (i == 3);
            neg(); chk("dly_req", 32'(MemReq_OUT), 32'd1);
            chk("dly_addr", MemAddr_OUT, 32'hBFC00004);
            nxt();
        end
        MemGnt_IN = 0; MemRvalid_IN = 1; MemRdata_IN = 32'h11111111;
        nxt(); MemRvalid_IN = 0;
        neg(); chk("d_miss_valid", 32'(InstructionValid_OUT), 32'd0);
        nxt(); MemGnt_IN = 1;
        neg(); chk("d2_req", 32'(MemReq_OUT), 32'd1);
        chk("d2_addr", MemAddr_OUT, 32'hBFC00100);
        nxt(); MemGnt_IN = 0; MemRvalid_IN = 1; MemRdata_IN = 32'h22222222;
        nxt(); MemRvalid_IN = 0;
        neg(); chk("d2_instr", Instruction_OUT, 32'h22222222);

        // flush while waiting: returned word dropped, same PC refetched
        Address_IN = 32'hBFC00200;
        nxt(); MemGnt_IN = 1;
        nxt(); MemGnt_IN = 0; Flush_IN = 1;
        nxt(); Flush_IN = 0; MemRvalid_IN = 1; MemRdata_IN = 32'hDEADBEEF;
        nxt(); MemRvalid_IN = 0;
        neg(); chk("fl_valid", 32'(InstructionValid_OUT), 32'd0);
        chk("fl_instr", Instruction_OUT, NOP);
        nxt(); MemGnt_IN = 1;
        neg(); chk("fl_req", 32'(MemReq_OUT), 32'd1);
        chk("fl_addr", MemAddr_OUT, 32'hBFC00200);
        nxt(); MemGnt_IN = 0; MemRvalid_IN = 1; MemRdata_IN = 32'hCAFEF00D;
        nxt(); MemRvalid_IN = 0;
        neg(); chk("fl_instr2", Instruction_OUT, 32'hCAFEF00D);
        chk("fl_valid2", 32'(InstructionValid_OUT), 32'd1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (rv_cnt == 0) begin
                MemRvalid_IN = 1; rv_cnt = -1;
            end else begin
                if (rv_cnt > 0) rv_cnt--;
                MemRvalid_IN = ($urandom_range(0, 29) == 0);
            end
            MemRdata_IN = $urandom;
            MemGnt_IN = MemReq_OUT ? 1'($urandom_range(0, 1))
                                   : ($urandom_range(0, 19) == 0);
            if (MemGnt_IN && MemReq_OUT) rv_cnt = $urandom_range(0, 4);
            if ($urandom_range(0, 3) == 0) Address_IN = pool[$urandom_range(0, 5)];
            Flush_IN = ($urandom_range(0, 11) == 0);
            nxt();
        end

        // let any in-flight fetch complete
        drained = 0;
        Flush_IN = 0; Address_IN = pool[0];
        for (int i = 0; i < 60 && !drained; i++) begin
            if (rv_cnt == 0) begin MemRvalid_IN = 1; rv_cnt = -1; end
            else begin if (rv_cnt > 0) rv_cnt--; MemRvalid_IN = 0; end
            MemGnt_IN = MemReq_OUT;
            if (MemGnt_IN) rv_cnt = 0;
            nxt();
            drained = !m_busy && rv_cnt < 0 && !MemRvalid_IN;
        end
        MemGnt_IN = 0; MemRvalid_IN = 0;
        chk("drain_done", 32'(drained), 32'd1);

        // rvalid never arrives: timeout lockup
        Address_IN = 32'hBFC00FF0;
        nxt(); MemGnt_IN = 1;
        neg(); chk("to_req", 32'(MemReq_OUT), 32'd1);
        nxt(); MemGnt_IN = 0;
        for (int w = 0; w < MAXW; w++) begin
            neg(); chk("to_berr0", 32'(BusError_OUT), 32'd0);
            nxt();
        end
        neg(); chk("to_berr1", 32'(BusError_OUT), 32'd1);
        chk("to_stall", 32'(Stall_OUT), 32'd1);
        nxt(); MemRvalid_IN = 1; MemRdata_IN = 32'h12345678;
        nxt(); MemRvalid_IN = 0;
        neg(); chk("late_berr", 32'(BusError_OUT), 32'd1);
        chk("late_valid", 32'(InstructionValid_OUT), 32'd0);
        chk("late_instr", Instruction_OUT, NOP);
        nxt(); RESET = 1'b0; #1;
        chk("rst2_berr", 32'(BusError_OUT), 32'd0);
        nxt(); RESET = 1'b1;

        // misaligned PC
        Address_IN = 32'hBFC00002;
        neg();
`ifdef IM_ALIGN_CHECK_EN
        chk("al_aerr", 32'(AddrError_OUT), 32'd1);
        chk("al_stall", 32'(Stall_OUT), 32'd0);
        chk("al_instr", Instruction_OUT, NOP);
        nxt(); neg();
        chk("al_req", 32'(MemReq_OUT), 32'd0);
`else
        chk("al_aerr", 32'(AddrError_OUT), 32'd0);
        nxt(); neg();
        chk("al_req", 32'(MemReq_OUT), 32'd1);
        chk("al_addr", MemAddr_OUT, 32'hBFC00002);
`endif
        nxt();
        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
